// File: rtl/clk_mon_checker_pkg.sv
// Shared definitions for the clock-monitor checker: FSM encoding and window-counter sizing.
package clk_mon_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One spare bit keeps WIN_LEN-1 representable for any power-of-two window.
  function automatic int win_cnt_w(input int win_len);
    return $clog2(win_len) + 1;
  endfunction

endpackage

// File: rtl/clk_mon_checker_chan.sv
// One monitored-clock channel: synchronizer, rising-edge detect, saturating edge counter
// and tolerance compare against the expected count.
module clk_mon_chan #(
  parameter int CNT_W = 8,
  parameter int TOL   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_clk_i,
  input  logic             clr_i,
  input  logic             cnt_en_i,
  input  logic             latch_i,
  input  logic [CNT_W-1:0] exp_cnt_i,
  output logic             fail_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] meas_cnt_o
);

  localparam logic [CNT_W:0] TOL_V = (CNT_W + 1)'(TOL);

  logic [1:0]       sync_q;
  logic             dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q;
  logic [CNT_W-1:0] meas_q;
  logic             edge_s;
  logic [CNT_W:0]   cnt_ext_s, exp_ext_s, diff_s;
  logic             within_s;

  assign edge_s = sync_q[1] & ~dly_q;

  // Synchronizer, edge-detect delay flop, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      dly_q  <= 1'b0;
      cnt_q  <= '0;
      pass_q <= 1'b0;
      meas_q <= '0;
    end else begin
      sync_q <= {sync_q[0], mon_clk_i};
      dly_q  <= sync_q[1];
      cnt_q  <= cnt_d;
      if (latch_i) begin
        pass_q <= within_s;
        meas_q <= cnt_q;
      end
    end
  end

  // Counter next state: clear on window entry, saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_en_i && edge_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Unsigned magnitude of the difference, one bit wider than the counter.
  always_comb begin
    cnt_ext_s = {1'b0, cnt_q};
    exp_ext_s = {1'b0, exp_cnt_i};
    if (cnt_ext_s >= exp_ext_s) begin
      diff_s = cnt_ext_s - exp_ext_s;
    end else begin
      diff_s = exp_ext_s - cnt_ext_s;
    end
    within_s = (diff_s <= TOL_V);
  end

  assign fail_o     = ~within_s;
  assign pass_o     = pass_q;
  assign meas_cnt_o = meas_q;

endmodule

// File: rtl/clk_mon_checker.sv
// Clock-monitor checker top: window FSM, per-channel instances, sticky error flags.
// Optional irq output/irq_mask input built when CLK_MON_IRQ_EN is defined.
module clk_mon_checker
  import clk_mon_checker_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 256,
  parameter int TOL     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    start,
  input  logic                    cont,
  input  logic                    err_clr,
  input  logic [NUM_CH-1:0]       mon_clk_i,
  input  logic [NUM_CH*CNT_W-1:0] exp_cnt_i,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH-1:0]       pass,
  output logic [NUM_CH-1:0]       err_sticky,
  output logic [NUM_CH*CNT_W-1:0] meas_cnt_o
`ifdef CLK_MON_IRQ_EN
  ,
  input  logic [NUM_CH-1:0]       irq_mask,
  output logic                    irq
`endif
);

  localparam int               WIN_W    = win_cnt_w(WIN_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

  state_e            state_q, state_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              clr_s, latch_s, cnt_en_s;
  logic [NUM_CH-1:0] fail_s;
  logic [NUM_CH-1:0] err_q, err_d;
  logic              busy_q, done_q;

  // State, window counter, sticky flags and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      err_q   <= err_d;
      busy_q  <= (state_d == ST_RUN) || (state_d == ST_CHECK);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Next-state logic; a low enable aborts from any state without a done pulse.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    clr_s   = 1'b0;
    latch_s = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            win_d   = '0;
            clr_s   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          win_d = win_q + {{(WIN_W-1){1'b0}}, 1'b1};
          if (win_q == WIN_LAST) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_CHECK: begin
          latch_s = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (cont) begin
            state_d = ST_RUN;
            win_d   = '0;
            clr_s   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The first RUN cycle is dead time so that start and re-arm windows behave alike.
  assign cnt_en_s = (state_q == ST_RUN) && (win_q != '0);

  // A new failure in the same cycle as err_clr must survive.
  assign err_d = (err_q & ~{NUM_CH{err_clr}}) | ({NUM_CH{latch_s}} & fail_s);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    clk_mon_chan #(
      .CNT_W (CNT_W),
      .TOL   (TOL)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .mon_clk_i  (mon_clk_i[k]),
      .clr_i      (clr_s),
      .cnt_en_i   (cnt_en_s),
      .latch_i    (latch_s),
      .exp_cnt_i  (exp_cnt_i[k*CNT_W +: CNT_W]),
      .fail_o     (fail_s[k]),
      .pass_o     (pass[k]),
      .meas_cnt_o (meas_cnt_o[k*CNT_W +: CNT_W])
    );
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err_sticky = err_q;

`ifdef CLK_MON_IRQ_EN
  logic irq_q;

  // Interrupt follows the masked sticky flags one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(err_q & irq_mask);
    end
  end

  assign irq = irq_q;
`endif

endmodule
